// File: rtl/mini_alu_stack.sv
// Two-stage (fetch/execute) 16-opcode core with a return-address stack and a
// one-cycle registered VRAM write port; HALT and stack errors freeze the core until Reset.
module mini_alu_stack #(
    parameter int DATA_W      = 16,
    parameter int REG_AW      = 8,
    parameter int IP_W        = 16,
    parameter int STACK_DEPTH = 4,
    parameter int ROW_W       = 6,
    parameter int COL_W       = 7,
    parameter int RGB_W       = 3
) (
    input  logic                     Clock,
    input  logic                     Reset,
    output logic [IP_W-1:0]          oIP,
    input  logic [4+3*REG_AW-1:0]    iInstruction,
    input  logic [DATA_W-1:0]        iExtData,
    output logic                     oVRAMWriteEnable,
    output logic [ROW_W+COL_W-1:0]   oVRAMAddress,
    output logic [RGB_W-1:0]         oVRAMData,
    output logic                     oHalted,
    output logic                     oFault
);

    localparam int INSTR_W = 4 + 3 * REG_AW;
    localparam int SP_W    = $clog2(STACK_DEPTH + 1);
    localparam int STK_AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_STO, OP_BLE, OP_BEQ, OP_JMP, OP_SMUL,
        OP_CALL, OP_RET, OP_INC, OP_MOV, OP_RGB, OP_STC, OP_IN, OP_HALT
    } op_t;

    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_FAULT} state_t;

    state_t state_q, state_next;

    logic [INSTR_W-1:0] instr_q;
    op_t                op;
    logic [REG_AW-1:0]  dst, src1, src0;

    logic [DATA_W-1:0]  regs [2**REG_AW];
    logic [IP_W-1:0]    stack [2**STK_AW];
    logic [SP_W-1:0]    sp_q, sp_m1;
    logic [RGB_W-1:0]   colour_q;

    logic [DATA_W-1:0]  a, b, wr_data;
    logic [IP_W-1:0]    target;
    logic               run, wr_en, redirect, push, pop;
    logic               halt_req, fault_req, rgb_load, stc;
    logic               stack_full, stack_empty;

    assign op   = op_t'(instr_q[INSTR_W-1 -: 4]);
    assign dst  = instr_q[3*REG_AW-1 -: REG_AW];
    assign src1 = instr_q[2*REG_AW-1 -: REG_AW];
    assign src0 = instr_q[REG_AW-1:0];

    assign a     = regs[src0];
    assign b     = regs[src1];
    assign sp_m1 = sp_q - SP_W'(1);
    assign run   = (state_q == ST_RUN);

    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);

    // Execute-stage decode: everything is gated by run so HALT/FAULT execute as NOP.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        wr_en     = 1'b0;
        wr_data   = '0;
        redirect  = 1'b0;
        target    = IP_W'(dst);
        push      = 1'b0;
        pop       = 1'b0;
        halt_req  = 1'b0;
        fault_req = 1'b0;
        rgb_load  = 1'b0;
        stc       = 1'b0;
        if (run) begin
            case (op)
                OP_ADD:  begin wr_en = 1'b1; wr_data = b + a; end
                OP_SUB:  begin wr_en = 1'b1; wr_data = b - a; end
                OP_STO:  begin wr_en = 1'b1; wr_data = DATA_W'({src1, src0}); end
                OP_BLE:  redirect = (b <= a);
                OP_BEQ:  redirect = (b == a);
                OP_JMP:  redirect = 1'b1;
                OP_SMUL: begin wr_en = 1'b1; wr_data = b * a; end
                OP_CALL: begin
                    if (stack_full) fault_req = 1'b1;
                    else begin push = 1'b1; redirect = 1'b1; end
                end
                OP_RET: begin
                    if (stack_empty) fault_req = 1'b1;
                    else begin
                        pop      = 1'b1;
                        redirect = 1'b1;
                        target   = stack[sp_m1[STK_AW-1:0]];
                    end
                end
                OP_INC:  begin wr_en = 1'b1; wr_data = b + DATA_W'(1); end
                OP_MOV:  begin wr_en = 1'b1; wr_data = b; end
                OP_RGB:  rgb_load = 1'b1;
                OP_STC:  stc = 1'b1;
                OP_IN:   begin wr_en = 1'b1; wr_data = iExtData; end
                OP_HALT: halt_req = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        // NOTE: state updates use <= so every flop samples pre-edge values,
        // independent of statement order inside the block.
        if (Reset) begin
            oIP              <= '0;
            instr_q          <= '0;
            sp_q             <= '0;
            colour_q         <= '0;
            oVRAMWriteEnable <= 1'b0;
            oVRAMAddress     <= '0;
            oVRAMData        <= '0;
        end else begin
            instr_q <= redirect ? '0 : iInstruction;
            if (run && !halt_req && !fault_req)
                oIP <= redirect ? target : oIP + IP_W'(1);
            if (push)     sp_q <= sp_q + SP_W'(1);
            else if (pop) sp_q <= sp_m1;
            if (rgb_load) colour_q <= src1[RGB_W-1:0];
            oVRAMWriteEnable <= stc;
            if (stc) begin
                oVRAMAddress <= {a[ROW_W-1:0], b[COL_W-1:0]};
                oVRAMData    <= colour_q;
            end
        end
    end

    // NOTE: storage arrays carry no reset; software must write a register before
    // reading it, and stack entries are only read below the stack pointer.
    always_ff @(posedge Clock) begin
        if (wr_en && !Reset) regs[dst] <= wr_data;
        if (push && !Reset)  stack[sp_q[STK_AW-1:0]] <= oIP;
    end

    always_ff @(posedge Clock) begin
        if (Reset) state_q <= ST_RUN;
        else       state_q <= state_next;
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_RUN: begin
                if (fault_req)     state_next = ST_FAULT;
                else if (halt_req) state_next = ST_HALT;
            end
            default: state_next = state_q;
        endcase
    end

    always_comb begin
        oHalted = (state_q != ST_RUN);
        oFault  = (state_q == ST_FAULT);
    end

endmodule
